// File: rtl/apb_sevenseg_ctrl_if.sv
// APB bus bundle for the seven-segment controller slot.
interface apb_sevenseg_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] pADDR;
    logic          pSEL;
    logic          pENABLE;
    logic          pWRITE;
    logic [DW-1:0] pWDATA;
    logic [DW-1:0] pRDATA;
    logic          pREADY;
    logic          pSLVERR;

    modport master (
        output pADDR, pSEL, pENABLE, pWRITE, pWDATA,
        input  pRDATA, pREADY, pSLVERR
    );

    modport slave (
        input  pADDR, pSEL, pENABLE, pWRITE, pWDATA,
        output pRDATA, pREADY, pSLVERR
    );
endinterface

// File: rtl/apb_sevenseg_ctrl.sv
// APB slave scanning a multiplexed common-anode seven-segment display with
// hex/raw digits, decimal points, PWM brightness, leading-zero blanking and blink.
module apb_sevenseg_ctrl #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE   = 1250
) (
    input  logic                  clock,
    input  logic                  reset,
    apb_sevenseg_ctrl_if.slave    apb,
    output logic [NUM_DIGITS-1:0] anode_select,
    output logic [6:0]            segs,
    output logic                  dp
);

    function automatic logic [31:0] nib_mask(input logic [7:0] m);
        logic [31:0] res;
        res = 32'd0;
        for (int i = 0; i < 8; i++) begin
            res[4*i +: 4] = {4{m[i]}};
        end
        return res;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        logic [31:0] res;
        res = 32'd0;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = {1'b0, {7{m[i]}}};
        end
        return res;
    endfunction

    // Active-low {g,f,e,d,c,b,a} hex glyphs.
    function automatic logic [6:0] seg_hex(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    localparam int             PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [2:0]     LAST_DIG  = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]     DIG_MASK  = 8'((9'd1 << NUM_DIGITS) - 9'd1);
    localparam logic [31:0]    NIB_MASK  = nib_mask(DIG_MASK);
    localparam logic [31:0]    LO_MASK   = byte_mask(DIG_MASK[3:0]);
    localparam logic [31:0]    HI_MASK   = byte_mask(DIG_MASK[7:4]);

    // Configuration registers
    logic        en_q, lzb_q;
    logic [3:0]  bright_q;
    logic [7:0]  blink_div_q;
    logic [31:0] digits_q, raw_lo_q, raw_hi_q;
    logic [7:0]  raw_mask_q, dp_mask_q, blink_mask_q;

    // Scan state
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    pwm_q, pwm_d;
    logic [2:0]    digit_q, digit_d;
    logic [7:0]    frame_q, frame_d;
    logic          blink_q, blink_d;

    // Output stage
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            segs_q, segs_d;
    logic                  dp_q, dp_d;

    logic          access_s, addr_err_s, err_s, wr_en_s;
    logic [DW-1:0] rd_val_s;
    logic [31:0]   wd_s;

    assign access_s   = apb.pSEL & apb.pENABLE;
    assign addr_err_s = (apb.pADDR[1:0] != 2'b00) | (|apb.pADDR[AW-1:5]);
    assign err_s      = addr_err_s | (apb.pWRITE & (apb.pADDR[4:2] == 3'd7));
    assign wr_en_s    = access_s & apb.pWRITE & ~err_s;
    assign wd_s       = apb.pWDATA[31:0];

    assign apb.pREADY  = access_s;
    assign apb.pSLVERR = access_s & err_s;
    assign apb.pRDATA  = (access_s & ~apb.pWRITE & ~addr_err_s) ? rd_val_s : {DW{1'b0}};

    // Read mux
    always_comb begin
        rd_val_s = {DW{1'b0}};
        case (apb.pADDR[4:2])
            3'd0:    rd_val_s = DW'({16'd0, blink_div_q, bright_q, 2'b00, lzb_q, en_q});
            3'd1:    rd_val_s = DW'(digits_q);
            3'd2:    rd_val_s = DW'({24'd0, raw_mask_q});
            3'd3:    rd_val_s = DW'(raw_lo_q);
            3'd4:    rd_val_s = DW'(raw_hi_q);
            3'd5:    rd_val_s = DW'({24'd0, dp_mask_q});
            3'd6:    rd_val_s = DW'({24'd0, blink_mask_q});
            3'd7:    rd_val_s = DW'({24'd0, pwm_q, blink_q, digit_q});
            default: rd_val_s = {DW{1'b0}};
        endcase
    end

    // Register file writes; bits for absent digits are never stored
    always_ff @(posedge clock) begin
        if (reset) begin
            en_q         <= 1'b0;
            lzb_q        <= 1'b0;
            bright_q     <= 4'hF;
            blink_div_q  <= 8'd0;
            digits_q     <= 32'd0;
            raw_mask_q   <= 8'd0;
            raw_lo_q     <= 32'd0;
            raw_hi_q     <= 32'd0;
            dp_mask_q    <= 8'd0;
            blink_mask_q <= 8'd0;
        end else if (wr_en_s) begin
            case (apb.pADDR[4:2])
                3'd0: begin
                    en_q        <= wd_s[0];
                    lzb_q       <= wd_s[1];
                    bright_q    <= wd_s[7:4];
                    blink_div_q <= wd_s[15:8];
                end
                3'd1:    digits_q     <= wd_s & NIB_MASK;
                3'd2:    raw_mask_q   <= wd_s[7:0] & DIG_MASK;
                3'd3:    raw_lo_q     <= wd_s & LO_MASK;
                3'd4:    raw_hi_q     <= wd_s & HI_MASK;
                3'd5:    dp_mask_q    <= wd_s[7:0] & DIG_MASK;
                3'd6:    blink_mask_q <= wd_s[7:0] & DIG_MASK;
                default: ;
            endcase
        end
    end

    // Scan counters: prescaler -> PWM phase -> digit -> frame -> blink phase
    always_comb begin
        logic frame_end;
        frame_end = 1'b0;
        presc_d   = presc_q;
        pwm_d     = pwm_q;
        digit_d   = digit_q;
        frame_d   = frame_q;
        blink_d   = blink_q;
        if (!en_q) begin
            presc_d = '0;
            pwm_d   = 4'd0;
            digit_d = 3'd0;
            frame_d = 8'd0;
            blink_d = 1'b1;
        end else begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                pwm_d   = pwm_q + 4'd1;
                if (pwm_q == 4'd15) begin
                    if (digit_q == LAST_DIG) begin
                        digit_d   = 3'd0;
                        frame_end = 1'b1;
                    end else begin
                        digit_d = digit_q + 3'd1;
                    end
                end else begin
                    digit_d = digit_q;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
            // >= so a BLINK_DIV lowered below the running count still toggles
            if (blink_div_q == 8'd0) begin
                frame_d = 8'd0;
                blink_d = 1'b1;
            end else if (frame_end) begin
                if ((frame_q + 8'd1) >= blink_div_q) begin
                    frame_d = 8'd0;
                    blink_d = ~blink_q;
                end else begin
                    frame_d = frame_q + 8'd1;
                end
            end else begin
                frame_d = frame_q;
            end
        end
    end

    // Scan state register
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            pwm_q   <= 4'd0;
            digit_q <= 3'd0;
            frame_q <= 8'd0;
            blink_q <= 1'b1;
        end else begin
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            digit_q <= digit_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
        end
    end

    // Digit visibility and glyph selection for the current slot
    always_comb begin
        logic [7:0] tail_zero;
        logic       run, blank, lit;
        logic [6:0] raw_byte, glyph;
        logic [3:0] nib;
        run = 1'b1;
        tail_zero = 8'd0;
        // tail_zero[i]: every digit from i upward is a hex zero
        for (int i = 7; i >= 0; i--) begin
            if (i < NUM_DIGITS) begin
                run = run & ~raw_mask_q[i] & (digits_q[4*i +: 4] == 4'd0);
            end else begin
                run = run;
            end
            tail_zero[i] = run;
        end
        blank    = lzb_q & (digit_q != 3'd0) & tail_zero[digit_q];
        lit      = en_q & (pwm_q <= bright_q) & ~(blink_mask_q[digit_q] & ~blink_q) & ~blank;
        raw_byte = digit_q[2] ? raw_hi_q[{digit_q[1:0], 3'b000} +: 7]
                              : raw_lo_q[{digit_q[1:0], 3'b000} +: 7];
        nib      = digits_q[{digit_q, 2'b00} +: 4];
        glyph    = raw_mask_q[digit_q] ? ~raw_byte : seg_hex(nib);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            anode_d[i] = ~(lit & (digit_q == 3'(i)));
        end
        segs_d = lit ? glyph : 7'h7F;
        dp_d   = lit ? ~dp_mask_q[digit_q] : 1'b1;
    end

    // Registered display outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            anode_q <= {NUM_DIGITS{1'b1}};
            segs_q  <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            anode_q <= anode_d;
            segs_q  <= segs_d;
            dp_q    <= dp_d;
        end
    end

    assign anode_select = anode_q;
    assign segs         = segs_q;
    assign dp           = dp_q;

endmodule
